// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decoded register fields and control bits from the
// pipeline stages toward the controller, and stall/flush/forward controls back.
interface pipeline_hazard_ctrl_if;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_uses_rs1;
  logic       if_id_uses_rs2;
  logic       if_id_halt;
  logic [4:0] id_ex_rs1;
  logic [4:0] id_ex_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_reg_write;
  logic       id_ex_mem_read;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_reg_write;
  logic [4:0] mem_wb_rd;
  logic       mem_wb_reg_write;
  logic       ex_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_hold;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       end_program;
  logic [1:0] ctrl_state;

  // master: the hazard controller; slave: the pipeline datapath
  modport master (
    input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2, if_id_halt,
    input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    input  ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
    input  ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
    output forwardA, forwardB, end_program, ctrl_state
  );

  modport slave (
    output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2, if_id_halt,
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    output ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
    output ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
    input  forwardA, forwardB, end_program, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stalls, flushes, dmem freeze, halt drain and
// EX forwarding. Define HAZARD_FORWARDING_EN to forward instead of RAW-stalling.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

  state_t     state_reg, state_next;
  logic [3:0] drain_cnt_reg, drain_cnt_next;
  logic       end_program_reg;

  logic [1:0][4:0] id_src;
  logic [1:0]      id_use;
  logic [1:0]      lu_hit;
  logic [1:0]      raw_hit;
  logic [1:0][1:0] fwd_sel;
  logic            mem_stall;
  logic            data_hazard;

  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, ex_mem_hold_c;

  assign id_src[0] = hz.if_id_rs1;
  assign id_src[1] = hz.if_id_rs2;
  assign id_use[0] = hz.if_id_uses_rs1;
  assign id_use[1] = hz.if_id_uses_rs2;

`ifdef HAZARD_FORWARDING_EN
  logic [1:0][4:0] ex_src;
  assign ex_src[0] = hz.id_ex_rs1;
  assign ex_src[1] = hz.id_ex_rs2;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{hz.id_ex_rs1, hz.id_ex_rs2, hz.mem_wb_rd, hz.mem_wb_reg_write};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign lu_hit[gi] = id_use[gi] && hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0)
                          && (id_src[gi] == hz.id_ex_rd);
`ifdef HAZARD_FORWARDING_EN
      assign raw_hit[gi] = 1'b0;
      // EX/MEM holds the younger result, so it wins over MEM/WB
      assign fwd_sel[gi] =
        (hz.ex_mem_reg_write && (hz.ex_mem_rd != 5'd0) && (hz.ex_mem_rd == ex_src[gi])) ? 2'b10 :
        (hz.mem_wb_reg_write && (hz.mem_wb_rd != 5'd0) && (hz.mem_wb_rd == ex_src[gi])) ? 2'b01 :
        2'b00;
`else
      // Without forwarding, any producer still in EX or MEM blocks decode
      assign raw_hit[gi] = id_use[gi] && (
        (hz.id_ex_reg_write  && (hz.id_ex_rd  != 5'd0) && (id_src[gi] == hz.id_ex_rd)) ||
        (hz.ex_mem_reg_write && (hz.ex_mem_rd != 5'd0) && (id_src[gi] == hz.ex_mem_rd)));
      assign fwd_sel[gi] = 2'b00;
`endif
    end
  endgenerate

  assign mem_stall   = hz.dmem_req && !hz.dmem_ready;
  assign data_hazard = (|lu_hit) || (|raw_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      drain_cnt_reg   <= 4'd0;
      end_program_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      drain_cnt_reg   <= drain_cnt_next;
      end_program_reg <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next      = state_reg;
    drain_cnt_next  = drain_cnt_reg;
    pc_write_c      = 1'b0;
    if_id_write_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_mem_hold_c   = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          ex_mem_hold_c = 1'b1;
          state_next    = MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          pc_write_c     = 1'b1;
        end else if (data_hazard) begin
          id_ex_bubble_c = 1'b1;
        end else if (hz.if_id_halt) begin
          id_ex_bubble_c = 1'b1;
          drain_cnt_next = 4'd1;
          state_next     = DRAIN;
        end else begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        // The completing cycle still holds; decode resumes one cycle later
        ex_mem_hold_c = 1'b1;
        if (hz.dmem_ready) state_next = RUN;
      end
      DRAIN: begin
        id_ex_bubble_c = 1'b1;
        if (mem_stall)                        ex_mem_hold_c  = 1'b1;
        else if (drain_cnt_reg == DRAIN_LAST) state_next     = HALTED;
        else                                  drain_cnt_next = drain_cnt_reg + 4'd1;
      end
      HALTED: begin
        id_ex_bubble_c = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.ex_mem_hold  = ex_mem_hold_c;
  assign hz.forwardA     = fwd_sel[0];
  assign hz.forwardB     = fwd_sel[1];
  assign hz.end_program  = end_program_reg;
  assign hz.ctrl_state   = state_reg;

endmodule
